muldiv_unit: RTL

- Iterative multiply/divide unit with architectural HI/LO registers for the single-issue MIPS core.
- Sits directly downstream of the register file: consumes rd1/rd2 as srca/srcb. Its hi/lo outputs feed the writeback mux (MFHI/MFLO) that drives wd3.
- Shift-add multiplier and restoring divider, 1 bit per cycle. The core stalls on busy.

---
 rtl/muldiv_pkg.sv | 15 +
 rtl/muldiv_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int WIDTH      = 32;
  localparam int ITER_COUNT = 32;

  typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} muldiv_op_t;
  typedef enum logic [1:0] {MD_IDLE, MD_ITER, MD_FIX, MD_DONE} muldiv_state_t;

  // Signed ops work on magnitudes; the sign is reapplied once the iteration ends.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic isSigned);
    return (isSigned && v[WIDTH-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider with HI/LO registers.
// Optional MULDIV_FAST_MUL_EN: single-cycle multiply computed in FIX, skipping ITER.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  muldiv_state_t      r_state;
  muldiv_op_t         r_op;
  logic [4:0]         r_count;
  logic               r_neg;
  logic               r_remNeg;
  logic               r_divZero;
  logic [WIDTH-1:0]   r_srcaRaw;
  logic [2*WIDTH-1:0] r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;

  logic               w_signedOp;
  logic               w_isMul;
  logic [WIDTH-1:0]   w_magA;
  logic [WIDTH-1:0]   w_magB;
  logic [2*WIDTH-1:0] w_mulNext;
  logic [WIDTH:0]     w_remShift;
  logic [WIDTH:0]     w_trial;
  logic               w_qBit;
  logic [2*WIDTH-1:0] w_divNext;
  logic [2*WIDTH-1:0] w_prodMag;
  logic [2*WIDTH-1:0] w_prodRes;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  assign w_signedOp = ~op[0];
  assign w_isMul    = ~r_op[1];
  assign w_magA     = magnitude(srca, w_signedOp);
  assign w_magB     = magnitude(srcb, w_signedOp);

  // r_acc holds the running product for MUL, and {remainder, dividend/quotient} for DIV.
  assign w_mulNext  = r_acc + (r_b[0] ? r_a : {(2*WIDTH){1'b0}});
  assign w_remShift = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_trial    = w_remShift - {1'b0, r_b};
  assign w_qBit     = ~w_trial[WIDTH];
  assign w_divNext  = {(w_qBit ? w_trial[WIDTH-1:0] : w_remShift[WIDTH-1:0]),
                       r_acc[WIDTH-2:0], w_qBit};

`ifdef MULDIV_FAST_MUL_EN
  assign w_prodMag = w_isMul ? (r_a * {{WIDTH{1'b0}}, r_b}) : r_acc;
`else
  assign w_prodMag = r_acc;
`endif

  assign w_prodRes = r_neg ? -w_prodMag : w_prodMag;
  assign w_quot    = r_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem     = r_remNeg ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= MD_IDLE;
      r_op      <= MD_MULT;
      r_count   <= '0;
      r_neg     <= 1'b0;
      r_remNeg  <= 1'b0;
      r_divZero <= 1'b0;
      r_srcaRaw <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          // A start in the same cycle as MTHI/MTLO takes priority and drops the write.
          if (start) begin
            r_op      <= muldiv_op_t'(op);
            r_count   <= 5'(ITER_COUNT - 1);
            r_neg     <= w_signedOp & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
            r_remNeg  <= w_signedOp & srca[WIDTH-1];
            r_divZero <= (srcb == '0);
            r_srcaRaw <= srca;
            r_a       <= {{WIDTH{1'b0}}, w_magA};
            r_b       <= w_magB;
            r_acc     <= op[1] ? {{WIDTH{1'b0}}, w_magA} : {(2*WIDTH){1'b0}};
            r_busy    <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
            r_state   <= op[1] ? MD_ITER : MD_FIX;
`else
            r_state   <= MD_ITER;
`endif
          end else begin
            if (hi_we) r_hi <= wd;
            if (lo_we) r_lo <= wd;
          end
        end
        MD_ITER: begin
          if (w_isMul) begin
            r_acc <= w_mulNext;
            r_a   <= {r_a[2*WIDTH-2:0], 1'b0};
            r_b   <= {1'b0, r_b[WIDTH-1:1]};
          end else begin
            r_acc <= w_divNext;
          end
          r_count <= r_count - 5'd1;
          if (r_count == 5'd0) r_state <= MD_FIX;
        end
        MD_FIX: begin
          if (w_isMul) begin
            {r_hi, r_lo} <= w_prodRes;
          end else if (r_divZero) begin
            r_hi <= r_srcaRaw;
            r_lo <= '1;
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quot;
          end
          r_done  <= 1'b1;
          r_state <= MD_DONE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= MD_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
